// File: rtl/yapay_zeka_carpma_birimi_pkg.sv
// Shared constants for the lane-wise dot-product consumer: drain depth, FSM encodings, default lane width.
package yapay_zeka_carpma_birimi_pkg;

  localparam int unsigned YZC_BOSALT_GECIKMESI = 2;
  localparam int unsigned YZC_SERIT_BIT        = 8;

  localparam logic [1:0] YZC_BOS    = 2'd0;
  localparam logic [1:0] YZC_CALIS  = 2'd1;
  localparam logic [1:0] YZC_BOSALT = 2'd2;
  localparam logic [1:0] YZC_SONUC  = 2'd3;

endpackage

// File: rtl/yapay_zeka_serit_carpici.sv
// One signed lane multiplier with a registered product that holds while the pipeline is stalled.
module yapay_zeka_serit_carpici
  import yapay_zeka_carpma_birimi_pkg::*;
#(
  parameter int unsigned SERIT_BIT = YZC_SERIT_BIT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ddb_durdur_i,
  input  logic signed [SERIT_BIT-1:0]   a_i,
  input  logic signed [SERIT_BIT-1:0]   b_i,
  output logic signed [2*SERIT_BIT-1:0] carpim_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carpim_o <= '0;
    end else if (!ddb_durdur_i) begin
      carpim_o <= a_i * b_i;
    end
  end

endmodule

// File: rtl/yapay_zeka_carpma_birimi.sv
// Accumulates the packed signed lane dot product over one RUN and presents the sum with a one-cycle valid.
// Define YAPAY_ZEKA_DOYGUNLUK_EN to saturate the accumulator on overflow instead of wrapping.
module yapay_zeka_carpma_birimi
  import yapay_zeka_carpma_birimi_pkg::*;
#(
  parameter int unsigned SERIT_SAYISI = 4,
  parameter int unsigned SERIT_BIT    = YZC_SERIT_BIT,
  parameter int unsigned TOPLAM_BIT   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ddb_durdur_i,
  input  logic                  carpma_rst_i,
  input  logic [31:0]           deger1_i,
  input  logic [31:0]           deger2_i,
  output logic [TOPLAM_BIT-1:0] sonuc_o,
  output logic                  sonuc_gecerli_o,
  output logic                  tasma_o
);

  localparam int unsigned GENIS_BIT = TOPLAM_BIT + 2*SERIT_BIT + $clog2(SERIT_SAYISI) + 1;
  localparam int unsigned SAYAC_BIT = $clog2(YZC_BOSALT_GECIKMESI + 1);

  logic [1:0]                             durum;
  logic [SAYAC_BIT-1:0]                   sayac;
  logic                                   gecerli1;
  logic [TOPLAM_BIT-1:0]                  akum;
  logic [TOPLAM_BIT-1:0]                  akum_sonraki;
  logic                                   tasma_r;
  logic                                   kabul;
  logic                                   tasar;
  logic [SERIT_SAYISI-1:0][2*SERIT_BIT-1:0] carpim;
  logic signed [GENIS_BIT-1:0]            agac;
  logic signed [GENIS_BIT-1:0]            tam;
  logic [GENIS_BIT-TOPLAM_BIT:0]          ust;

  // Beats arriving while draining or presenting a result are not captured.
  assign kabul = !carpma_rst_i && !ddb_durdur_i && ((durum == YZC_BOS) || (durum == YZC_CALIS));

  for (genvar k = 0; k < SERIT_SAYISI; k++) begin : g_serit
    yapay_zeka_serit_carpici #(
      .SERIT_BIT(SERIT_BIT)
    ) u_carpici (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ddb_durdur_i(ddb_durdur_i),
      .a_i         (deger1_i[k*SERIT_BIT +: SERIT_BIT]),
      .b_i         (deger2_i[k*SERIT_BIT +: SERIT_BIT]),
      .carpim_o    (carpim[k])
    );
  end

  // Sum is formed wide so that both tree and accumulate overflow show up as non-sign bits above the result.
  always_comb begin
    agac = '0;
    for (int unsigned k = 0; k < SERIT_SAYISI; k++) begin
      agac = agac + GENIS_BIT'($signed(carpim[k]));
    end
    tam   = GENIS_BIT'($signed(akum)) + agac;
    ust   = tam[GENIS_BIT-1:TOPLAM_BIT-1];
    tasar = !((ust == '0) || (ust == '1));
`ifdef YAPAY_ZEKA_DOYGUNLUK_EN
    if (tasma_r) begin
      akum_sonraki = akum;
    end else if (tasar) begin
      akum_sonraki = tam[GENIS_BIT-1] ? {1'b1, {(TOPLAM_BIT-1){1'b0}}}
                                      : {1'b0, {(TOPLAM_BIT-1){1'b1}}};
    end else begin
      akum_sonraki = tam[TOPLAM_BIT-1:0];
    end
`else
    akum_sonraki = tam[TOPLAM_BIT-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum    <= YZC_BOS;
      sayac    <= '0;
      gecerli1 <= 1'b0;
      akum     <= '0;
      tasma_r  <= 1'b0;
      sonuc_o  <= '0;
      tasma_o  <= 1'b0;
    end else if (!ddb_durdur_i) begin
      gecerli1 <= kabul;
      if (kabul && (durum == YZC_BOS)) begin
        akum    <= '0;
        tasma_r <= 1'b0;
      end else if (gecerli1) begin
        akum    <= akum_sonraki;
        tasma_r <= tasma_r | tasar;
      end

      case (durum)
        YZC_BOS: begin
          if (kabul) durum <= YZC_CALIS;
        end
        YZC_CALIS: begin
          if (carpma_rst_i) begin
            durum <= YZC_BOSALT;
            sayac <= SAYAC_BIT'(YZC_BOSALT_GECIKMESI);
          end
        end
        YZC_BOSALT: begin
          // Result is latched on the edge the counter reaches 0 so it is visible during SONUC.
          sayac <= sayac - SAYAC_BIT'(1);
          if (sayac == SAYAC_BIT'(1)) begin
            durum   <= YZC_SONUC;
            sonuc_o <= akum;
            tasma_o <= tasma_r;
          end
        end
        default: begin
          durum <= YZC_BOS;
        end
      endcase
    end
  end

  assign sonuc_gecerli_o = (durum == YZC_SONUC);

endmodule

// File: tb/tb_yapay_zeka_carpma_birimi.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare on each valid pulse.
module tb_yapay_zeka_carpma_birimi;

  logic        clk = 1'b0;
  logic        rst, durdur, crst, crst2;
  logic [31:0] d1, d2;
  logic [31:0] sonuc;
  logic        gecerli, tasma;
  logic [15:0] sonuc16;
  logic        gecerli16, tasma16;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] sonuc;
    logic        tasma;
    int unsigned cyc;
  } bek_t;

  bek_t q[$];
  bek_t q16[$];
  bek_t e, e16;
  int unsigned t0;
  logic [15:0] exp16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yapay_zeka_carpma_birimi #(
    .SERIT_SAYISI(4),
    .SERIT_BIT   (8),
    .TOPLAM_BIT  (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ddb_durdur_i   (durdur),
    .carpma_rst_i   (crst),
    .deger1_i       (d1),
    .deger2_i       (d2),
    .sonuc_o        (sonuc),
    .sonuc_gecerli_o(gecerli),
    .tasma_o        (tasma)
  );

  yapay_zeka_carpma_birimi #(
    .SERIT_SAYISI(4),
    .SERIT_BIT   (8),
    .TOPLAM_BIT  (16)
  ) dut16 (
    .clk_i          (clk),
    .rst_i          (rst),
    .ddb_durdur_i   (durdur),
    .carpma_rst_i   (crst2),
    .deger1_i       (d1),
    .deger2_i       (d2),
    .sonuc_o        (sonuc16),
    .sonuc_gecerli_o(gecerli16),
    .tasma_o        (tasma16)
  );

  task automatic chk(input string ad, input logic [31:0] got, input logic [31:0] bek);
    checks++;
    if (got !== bek) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", ad, got, bek);
    end
  endtask

  always @(negedge clk) begin
    if (gecerli) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d sonuc=%h expected=no_pulse", cyc, sonuc);
      end else begin
        e = q.pop_front();
        chk("sonuc", sonuc, e.sonuc);
        chk("tasma", {31'd0, tasma}, {31'd0, e.tasma});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (gecerli16) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse16 cyc=%0d sonuc=%h expected=no_pulse", cyc, sonuc16);
      end else begin
        e16 = q16.pop_front();
        chk("sonuc16", {16'd0, sonuc16}, e16.sonuc);
        chk("tasma16", {31'd0, tasma16}, {31'd0, e16.tasma});
        chk("pulse_cycle16", cyc, e16.cyc);
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    crst = 1'b0;
    d1   = a;
    d2   = b;
    @(posedge clk); #1;
  endtask

  task automatic bitir(input logic [31:0] s, input logic t, input int unsigned exp_cyc);
    crst = 1'b1;
    q.push_back('{sonuc: s, tasma: t, cyc: exp_cyc});
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; durdur = 1'b0; crst = 1'b1; crst2 = 1'b1; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_sonuc", sonuc, 32'd0);
    chk("reset_tasma", {31'd0, tasma}, 32'd0);
    chk("reset_gecerli", {31'd0, gecerli}, 32'd0);
    chk("reset_sonuc16", {16'd0, sonuc16}, 32'd0);

    beat(32'h01020304, 32'h01010101);
    bitir(32'd10, 1'b0, cyc + 3);

    repeat (16) beat(32'h7F7F7F7F, 32'h7F7F7F7F);
    bitir(32'h000FC040, 1'b0, cyc + 3);

    beat(32'hFFFFFFFF, 32'h01010101);
    beat(32'h80000000, 32'h02000000);
    bitir(32'hFFFFFEFC, 1'b0, cyc + 3);

    // reference run: 3 beats of 4*8+3*7+2*6+1*5 = 70
    t0 = cyc;
    repeat (3) beat(32'h01020304, 32'h05060708);
    bitir(32'd210, 1'b0, t0 + 6);

    t0 = cyc;
    beat(32'h01020304, 32'h05060708);
    beat(32'h01020304, 32'h05060708);
    durdur = 1'b1;
    crst   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    durdur = 1'b0;
    beat(32'h01020304, 32'h05060708);
    bitir(32'd210, 1'b0, t0 + 11);

`ifdef YAPAY_ZEKA_DOYGUNLUK_EN
    exp16 = 16'h7FFF;
`else
    exp16 = 16'h0000;
`endif
    d1 = 32'h80808080;
    d2 = 32'h80808080;
    crst2 = 1'b0;
    @(posedge clk); #1;
    crst2 = 1'b1;
    q16.push_back('{sonuc: {16'd0, exp16}, tasma: 1'b1, cyc: cyc + 3});
    repeat (8) @(posedge clk);
    #1;

    beat(32'h01010101, 32'h01010101);
    beat(32'h01010101, 32'h01010101);
    rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    crst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_reset_sonuc", sonuc, 32'd0);
    chk("midrun_reset_tasma", {31'd0, tasma}, 32'd0);

    beat(32'h00000002, 32'h00000003);
    bitir(32'd6, 1'b0, cyc + 3);

    chk("queue_empty", q.size(), 32'd0);
    chk("queue16_empty", q16.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yapay_zeka_carpma_birimi.md
Name: yapay_zeka_carpma_birimi

Overview:
- Consumer end of the accelerator's operand stream.
- Takes the two 32-bit operand words driven each RUN cycle, plus the active-low-run carpma_rst signal, from the accelerator controller.
- Treats each word as packed signed lanes and accumulates the lane-wise dot product over one whole RUN.
- Presents the final sum to the X-instruction writeback with a one-cycle valid pulse.

Parameters:
- SERIT_SAYISI, 4: number of packed lanes per operand word.
- SERIT_BIT, 8: signed width of one lane. SERIT_SAYISI*SERIT_BIT must equal 32.
- TOPLAM_BIT, 32: accumulator and result width, between 16 and 32 inclusive.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- ddb_durdur_i  input  1  pipeline stall; freezes all state.
- carpma_rst_i  input  1  1 = idle/no operand, 0 = operand pair valid (RUN beat).
- deger1_i  input  32  data-bank operand word (packed signed lanes).
- deger2_i  input  32  coefficient-bank operand word (packed signed lanes).
- sonuc_o  output  TOPLAM_BIT  result of the most recently completed RUN.
- sonuc_gecerli_o  output  1  one-cycle pulse when sonuc_o is updated.
- tasma_o  output  1  overflow occurred during the RUN that produced sonuc_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: sonuc_o=0, sonuc_gecerli_o=0, tasma_o=0, accumulator=0, all pipeline valid bits=0, FSM=BOS.
- Accepted beat: a beat is accepted on a rising edge when carpma_rst_i==0 and ddb_durdur_i==0.
- Pipeline stages:
  - Stage 1 (edge after accept): SERIT_SAYISI signed products deger1 lane k × deger2 lane k, each 2*SERIT_BIT wide, registered with a valid bit. Lane 0 = bits [SERIT_BIT-1:0].
  - Stage 2 (next edge): products sign-extended to TOPLAM_BIT, summed by an adder tree, and added to the accumulator when the stage-1 valid bit is set.
  - Latency: accepted beat to accumulator update = 2 edges.
- Stall: while ddb_durdur_i=1, every register (stage valids, products, accumulator, FSM, outputs) holds. carpma_rst_i is ignored while stalled; a stall never ends a RUN.
- FSM states:
  - BOS: on an accepted beat, clear the accumulator and tasma flag in the same edge that captures stage 1, then go to CALIS.
  - CALIS: accept beats. On carpma_rst_i==1 with no stall, go to BOSALT and load the drain counter with 2.
  - BOSALT: decrement the drain counter on each non-stalled cycle. At 0, go to SONUC.
  - SONUC: latch sonuc_o=accumulator and tasma_o=running flag, assert sonuc_gecerli_o for exactly this cycle, then go to BOS.
- Result hold: sonuc_o and tasma_o keep their values until the next SONUC.
- New RUN while draining: if carpma_rst_i returns to 0 while in BOSALT/SONUC, that beat is captured into stage 1 but accumulates into a fresh sum only after the current result is latched. An implementation may instead forbid this. The controller guarantees at least 1 idle cycle, so either is conforming; the bench does not exercise it.
- Overflow: tasma flag sets when the signed TOPLAM_BIT add overflows (operand signs equal, result sign differs). It is sticky within the RUN.
- Empty RUN: a RUN with zero accepted beats cannot occur, because BOS only leaves on a beat.
- Reset mid-RUN: everything returns to reset values on the next edge; no sonuc_gecerli_o pulse.

Optional Feature:
- Macro: YAPAY_ZEKA_DOYGUNLUK_EN.
- Defined: on overflow the accumulator clamps to the max/min signed TOPLAM_BIT value and stays clamped for the remainder of the RUN in the overflow direction. tasma_o is still reported.
- Undefined: two's-complement wrap; tasma_o is still reported.

Decomposition:
- Add to tanimlamalar.vh:
  - drain-depth constant YZC_BOSALT_GECIKMESI = 2.
  - FSM state encodings YZC_BOS, YZC_CALIS, YZC_BOSALT, YZC_SONUC.
  - default lane width.
- Sub-module yapay_zeka_serit_carpici: one signed SERIT_BIT×SERIT_BIT registered multiplier with hold-on-stall. Instantiated SERIT_SAYISI times via generate.

Test Plan:
- Single beat 0x01020304 × 0x01010101, then carpma_rst_i=1 → sonuc_gecerli_o pulses 3 cycles after carpma_rst_i rises; sonuc_o = 10; tasma_o = 0.
- 16 beats of 0x7F7F7F7F × 0x7F7F7F7F → sonuc_o = 1032256 (0x000FC040).
- Negative lanes: 0xFFFFFFFF × 0x01010101, then 0x80000000 × 0x02000000 → sonuc_o = -4 + (-256) = 0xFFFFFEFC.
- ddb_durdur_i held 5 cycles mid-RUN with carpma_rst_i=1 during the stall → no early pulse; sum equals the unstalled reference run; pulse timing shifts by exactly 5 cycles.
- TOPLAM_BIT=16, one beat 0x80808080 × 0x80808080 → tasma_o=1. sonuc_o=0x7FFF with YAPAY_ZEKA_DOYGUNLUK_EN, 0x0000 without.
- rst_i asserted at beat 3 of 8 → no pulse; sonuc_o=0. A following 1-beat RUN of 0x00000002 × 0x00000003 → sonuc_o = 6.
